// File: rtl/rayee_if.sv
// Pad-ring bundle for the rayee_demo tile: enable, dedicated inputs, bidirectional data bus.
interface rayee_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/rayee_demo.sv
// 8-bit demo engine (counter / LFSR / PWM / load) with a shared power-of-two prescaler.
// Optional status outputs on uio[7:6] are enabled by defining RAYEE_STATUS_EN.
module rayee_demo #(
  parameter int PRESCALE_W = 16
) (
  input logic    clk,
  input logic    rst_n,
  rayee_if.slave bus
);

  localparam logic [1:0] MODE_CNT  = 2'b00;
  localparam logic [1:0] MODE_LFSR = 2'b01;
  localparam logic [1:0] MODE_PWM  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Taps 8,6,5,4; an all-zero register is forced back to 0x01.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    if (s == 8'h00) return 8'h01;
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [7:0] pwm_byte(input logic [7:0] phase, input logic [7:0] duty);
    return {7'b0, (phase < duty)};
  endfunction

  logic [1:0]            mode;
  logic [3:0]            p;
  logic                  en;
  logic                  tick;
  logic [7:0]            data;
  logic [PRESCALE_W-1:0] mask;
  logic [PRESCALE_W-1:0] prescaler;
  logic [7:0]            cnt;
  logic [7:0]            lfsr;
  logic [7:0]            pwm_cnt;
  logic [7:0]            out_mux;
  logic [7:0]            uo_p1;

  assign mode = bus.ui_in[1:0];
  assign p    = bus.ui_in[7:4];
  assign en   = bus.ena & bus.ui_in[2];

`ifdef RAYEE_STATUS_EN
  assign data = {2'b00, bus.uio_in[5:0]};
  logic unused_in;
  assign unused_in = ^{bus.ui_in[3], bus.uio_in[7:6]};
`else
  assign data = bus.uio_in;
  logic unused_in;
  assign unused_in = bus.ui_in[3];
`endif

  // With p = 0 the mask is empty, so every enabled cycle ticks.
  always_comb begin
    mask = (PRESCALE_W'(1) << p) - PRESCALE_W'(1);
    tick = en & ((prescaler & mask) == mask);
  end

  always_comb begin
    out_mux = cnt;
    case (mode)
      MODE_LFSR: out_mux = lfsr;
      MODE_PWM:  out_mux = pwm_byte(pwm_cnt, data);
      default:   out_mux = cnt;
    endcase
  end

  // Stage p0 -> p1: state update and output register share the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      cnt       <= 8'h00;
      lfsr      <= 8'h01;
      pwm_cnt   <= 8'h00;
      uo_p1     <= 8'h00;
    end else begin
      if (en) prescaler <= prescaler + PRESCALE_W'(1);
      case (mode)
        MODE_CNT:  if (tick) cnt     <= cnt + 8'd1;
        MODE_LFSR: if (tick) lfsr    <= lfsr_next(lfsr);
        MODE_PWM:  if (tick) pwm_cnt <= pwm_cnt + 8'd1;
        MODE_LOAD: if (en)   cnt     <= data;
        default: ;
      endcase
      uo_p1 <= out_mux;
    end
  end

  assign bus.uo_out = uo_p1;

`ifdef RAYEE_STATUS_EN
  logic tick_p1;
  logic vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      tick_p1 <= tick;
      vld_p1  <= en;
    end
  end

  assign bus.uio_out = {tick_p1, vld_p1, 6'b0};
  assign bus.uio_oe  = 8'hC0;
`else
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_rayee_demo.sv
// Directed bench for rayee_demo (default build): vector table plus prescaler, LFSR, PWM and async-reset sequences.
module tb_rayee_demo;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  rayee_if bus ();

  rayee_demo #(.PRESCALE_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ui;
    logic [7:0] uio;
    logic       ena;
    logic [7:0] exp_uo;
  } vec_t;

  vec_t tbl [29];

`ifdef RAYEE_STATUS_EN
  localparam logic [7:0] EXP_OE = 8'hC0;
`else
  localparam logic [7:0] EXP_OE = 8'h00;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] ui, input logic [7:0] uio, input logic ena);
    bus.ui_in  = ui;
    bus.uio_in = uio;
    bus.ena    = ena;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int hi;
    int bad;
    int ones;
    logic [7:0] held;
    logic [7:0] lfsr_exp [6];

    // Reset state with arbitrary inputs and a running clock.
    rst_n = 1'b0;
    drive(8'hFF, 8'hA5, 1'b1);
    step();
    step();
    check("reset_uo", bus.uo_out, 8'h00);
    check("reset_uio_out", bus.uio_out, 8'h00);
    check("reset_uio_oe", bus.uio_oe, EXP_OE);

    // Vector table: count, load-then-count wrap, freezes, mode independence, PWM.
    for (int i = 0; i < 10; i++) tbl[i] = '{8'h04, 8'h00, 1'b1, 8'(i)};
    tbl[10] = '{8'h04, 8'h00, 1'b1, 8'h0A};
    tbl[11] = '{8'h07, 8'hFE, 1'b1, 8'h0B};
    tbl[12] = '{8'h07, 8'hFE, 1'b1, 8'hFE};
    tbl[13] = '{8'h04, 8'hFE, 1'b1, 8'hFE};
    tbl[14] = '{8'h04, 8'hFE, 1'b1, 8'hFF};
    tbl[15] = '{8'h04, 8'hFE, 1'b1, 8'h00};
    tbl[16] = '{8'h04, 8'hFE, 1'b1, 8'h01};
    tbl[17] = '{8'h04, 8'h00, 1'b0, 8'h02};
    tbl[18] = '{8'h04, 8'h00, 1'b0, 8'h02};
    tbl[19] = '{8'h00, 8'h00, 1'b1, 8'h02};
    tbl[20] = '{8'h00, 8'h00, 1'b1, 8'h02};
    tbl[21] = '{8'h04, 8'h00, 1'b1, 8'h02};
    tbl[22] = '{8'h04, 8'h00, 1'b1, 8'h03};
    tbl[23] = '{8'h05, 8'h00, 1'b1, 8'h01};
    tbl[24] = '{8'h04, 8'h00, 1'b1, 8'h04};
    tbl[25] = '{8'h05, 8'h00, 1'b1, 8'h02};
    tbl[26] = '{8'h06, 8'h01, 1'b1, 8'h01};
    tbl[27] = '{8'h06, 8'h01, 1'b1, 8'h00};
    tbl[28] = '{8'h06, 8'h05, 1'b1, 8'h01};

    drive(8'h04, 8'h00, 1'b1);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].ui, tbl[i].uio, tbl[i].ena);
      step();
      check($sformatf("vec%0d_uo", i), bus.uo_out, tbl[i].exp_uo);
    end
`ifndef RAYEE_STATUS_EN
    check("uio_out_idle", bus.uio_out, 8'h00);
`endif

    // Prescaler p=2: one increment per 4 enabled cycles, held across a freeze.
    drive(8'h24, 8'h00, 1'b1);
    pulse_reset();
    for (int k = 1; k <= 14; k++) begin
      step();
      check($sformatf("p2_edge%0d", k), bus.uo_out, 8'((k - 1) / 4));
    end
    bad = 0;
    for (int k = 0; k < 19; k++) begin
      if (k < 10) drive(8'h20, 8'h00, 1'b1);
      else        drive(8'h24, 8'h00, 1'b0);
      step();
      if (bus.uo_out !== 8'h03) bad++;
    end
    check("freeze_uo_const", bad, 0);
    drive(8'h24, 8'h00, 1'b1);
    step();
    check("resume_e15", bus.uo_out, 8'h03);
    step();
    check("resume_e16", bus.uo_out, 8'h03);
    step();
    check("resume_e17", bus.uo_out, 8'h04);

    // LFSR sequence and period.
    lfsr_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    drive(8'h05, 8'h00, 1'b1);
    pulse_reset();
    ones = 0;
    bad  = 0;
    for (int k = 1; k <= 256; k++) begin
      step();
      if (k <= 6) check($sformatf("lfsr_%0d", k), bus.uo_out, lfsr_exp[k-1]);
      if (k >= 2 && k <= 255 && bus.uo_out == 8'h01) ones++;
      if (bus.uo_out == 8'h00) bad++;
    end
    check("lfsr_period_255", bus.uo_out, 8'h01);
    check("lfsr_no_early_repeat", ones, 0);
    check("lfsr_never_zero", bad, 0);

    // PWM duty 0x40, 0x00 and 0xFF over full 256-tick periods.
    drive(8'h06, 8'h40, 1'b1);
    pulse_reset();
    for (int d = 0; d < 3; d++) begin
      if (d == 1) bus.uio_in = 8'h00;
      if (d == 2) bus.uio_in = 8'hFF;
      hi  = 0;
      bad = 0;
      for (int k = 0; k < 256; k++) begin
        step();
        if (bus.uo_out[0]) hi++;
        if (bus.uo_out[7:1] != 7'd0) bad++;
      end
      check($sformatf("pwm_high_d%0d", d), hi, (d == 0) ? 64 : (d == 1) ? 0 : 255);
      check($sformatf("pwm_upper_d%0d", d), bad, 0);
    end

    // Asynchronous reset mid-count, then counting resumes from zero.
    drive(8'h04, 8'h00, 1'b1);
    pulse_reset();
    for (int k = 0; k < 8'h38; k++) step();
    held = bus.uo_out;
    check("pre_reset_uo", held, 8'h37);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_uo", bus.uo_out, 8'h00);
    #1;
    rst_n = 1'b1;
    step();
    check("post_reset_e1", bus.uo_out, 8'h00);
    step();
    check("post_reset_e2", bus.uo_out, 8'h01);
    step();
    check("post_reset_e3", bus.uo_out, 8'h02);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
